ct_pt_addsub_stream: RTL and testbench

CT_PT_ADDSUB_STREAM -- requirements
Module: ct_pt_addsub_stream

---
 rtl/ct_pt_addsub_stream_pkg.sv | 11 +
 rtl/ct_pt_addsub_stream_mod_q_reduce.sv | 18 +
 rtl/ct_pt_addsub_stream.sv | 171 +++++++++++++++++
 tb/tb_ct_pt_addsub_stream.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ct_pt_addsub_stream_pkg.sv
// Shared types for the plaintext add/sub stream: default modulus, scale, slot count and word width.
package ct_pt_addsub_stream_pkg;

  localparam int Q_MOD_L   = 97;
  localparam int DELTA_L   = 8;
  localparam int N_SLOTS_L = 8;
  localparam int W_BITS_L  = 16;

  typedef logic [W_BITS_L-1:0] word_t;

endpackage

// File: rtl/ct_pt_addsub_stream_mod_q_reduce.sv
// Combinational reduction of a signed 2W-bit value to its residue in [0,q).
module mod_q_reduce #(
  parameter int W  = 16,
  parameter int QP = 97
) (
  input  logic signed [2*W-1:0] i_x,
  output logic        [W-1:0]   o_r
);

  localparam logic signed [2*W-1:0] Q_S = (2*W)'(QP);

  logic signed [2*W-1:0] w_rem;

  // % truncates toward zero, so a negative dividend leaves a remainder in (-q,0]
  assign w_rem = i_x % Q_S;
  assign o_r   = W'((w_rem < 0) ? (w_rem + Q_S) : w_rem);

endmodule

// File: rtl/ct_pt_addsub_stream.sv
// B' = (B +/- delta*gamma) mod q per lane, 3-stage valid/ready pipeline (mul, reduce, add/sub), one beat/cycle.
// Optional CT_PT_ADDSUB_FRAMING_CHECK_EN adds a sticky err_framing flag comparing in_last with the beat counter.
module ct_pt_addsub_stream
  import ct_pt_addsub_stream_pkg::*;
#(
  parameter int N      = N_SLOTS_L,
  parameter int LANES  = 4,
  parameter int W      = W_BITS_L,
  parameter int QP     = Q_MOD_L,
  parameter int DELTAP = DELTA_L
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sub,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [LANES*W-1:0] in_gamma,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_a,
  output logic [LANES*W-1:0] out_b,
  output logic               out_last
`ifdef CT_PT_ADDSUB_FRAMING_CHECK_EN
  ,
  output logic               err_framing
`endif
);

  localparam int                      BEATS   = N / LANES;
  localparam int                      CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]           TERM    = CW'(BEATS - 1);
  localparam logic signed [2*W-1:0]   DELTA_X = (2*W)'(DELTAP);
  localparam logic [W:0]              Q_W1    = (W+1)'(QP);

  logic               r_rdy_en;
  logic [CW-1:0]      r_cnt;
  logic               r_mode;
  logic               w_in_fire, w_s1_en, w_s2_en, w_s3_en, w_term, w_mode;

  logic               r_s1_vld, r_s1_sub, r_s1_last;
  logic [LANES*W-1:0] r_s1_a, r_s1_b;
  logic               r_s2_vld, r_s2_sub, r_s2_last;
  logic [LANES*W-1:0] r_s2_a, r_s2_b;
  logic               r_s3_vld, r_s3_last;
  logic [LANES*W-1:0] r_s3_a, r_s3_b;
  logic [LANES*W-1:0] w_s3_b;

  // A stage loads when it is empty or its contents move on this edge
  assign w_s3_en   = !r_s3_vld || out_ready;
  assign w_s2_en   = !r_s2_vld || w_s3_en;
  assign w_s1_en   = !r_s1_vld || w_s2_en;
  assign in_ready  = r_rdy_en && w_s1_en;
  assign w_in_fire = in_valid && in_ready;
  assign w_term    = (r_cnt == TERM);
  assign w_mode    = (r_cnt == '0) ? in_sub : r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_in_fire) begin
        r_cnt  <= w_term ? '0 : r_cnt + CW'(1);
        r_mode <= w_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_sub  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_sub  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_a    <= '0;
      r_s2_b    <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_last <= 1'b0;
      r_s3_a    <= '0;
      r_s3_b    <= '0;
    end else begin
      if (w_s1_en) r_s1_vld <= w_in_fire;
      if (w_in_fire) begin
        r_s1_sub  <= w_mode;
        r_s1_last <= w_term;
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
      end
      if (w_s2_en) r_s2_vld <= r_s1_vld;
      if (w_s2_en && r_s1_vld) begin
        r_s2_sub  <= r_s1_sub;
        r_s2_last <= r_s1_last;
        r_s2_a    <= r_s1_a;
        r_s2_b    <= r_s1_b;
      end
      if (w_s3_en) r_s3_vld <= r_s2_vld;
      if (w_s3_en && r_s2_vld) begin
        r_s3_last <= r_s2_last;
        r_s3_a    <= r_s2_a;
        r_s3_b    <= w_s3_b;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [W-1:0]   w_gam;
    logic signed [2*W-1:0] r_prod;
    logic [W-1:0]          w_red;
    logic [W-1:0]          r_dg;
    logic [W:0]            w_sum, w_dif;
    logic [W-1:0]          w_res;

    assign w_gam = in_gamma[l*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prod <= '0;
        r_dg   <= '0;
      end else begin
        if (w_in_fire) r_prod <= DELTA_X * (2*W)'(w_gam);
        if (w_s2_en && r_s1_vld) r_dg <= w_red;
      end
    end

    mod_q_reduce #(.W(W), .QP(QP)) u_reduce (
      .i_x (r_prod),
      .o_r (w_red)
    );

    // Both operands are already in [0,q), so one correction step suffices
    assign w_sum = {1'b0, r_s2_b[l*W +: W]} + {1'b0, r_dg};
    assign w_dif = {1'b0, r_s2_b[l*W +: W]} - {1'b0, r_dg};

    always_comb begin
      w_res = '0;
      if (r_s2_sub) w_res = w_dif[W] ? W'(w_dif + Q_W1) : w_dif[W-1:0];
      else          w_res = (w_sum >= Q_W1) ? W'(w_sum - Q_W1) : w_sum[W-1:0];
    end

    assign w_s3_b[l*W +: W] = w_res;
  end

  assign out_valid = r_s3_vld;
  assign out_last  = r_s3_last;
  assign out_a     = r_s3_a;
  assign out_b     = r_s3_b;

`ifdef CT_PT_ADDSUB_FRAMING_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (w_in_fire && (in_last != w_term)) r_err <= 1'b1;
  end

  assign err_framing = r_err;
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
`endif

endmodule

// File: tb/tb_ct_pt_addsub_stream.sv
// Directed bench for ct_pt_addsub_stream with q=97, delta=8, N=8, LANES=4 (two beats per polynomial).
module tb_ct_pt_addsub_stream;

  localparam int N = 8, LANES = 4, W = 16, QP = 97, DP = 8, NV = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready, in_sub, in_last;
  logic [LANES*W-1:0] in_a, in_b, in_gamma;
  logic               out_valid, out_ready, out_last;
  logic [LANES*W-1:0] out_a, out_b;
`ifdef CT_PT_ADDSUB_FRAMING_CHECK_EN
  logic               err_framing;
`endif

  always #5 clk = ~clk;

  ct_pt_addsub_stream #(.N(N), .LANES(LANES), .W(W), .QP(QP), .DELTAP(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b), .in_gamma(in_gamma), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_last(out_last)
`ifdef CT_PT_ADDSUB_FRAMING_CHECK_EN
    , .err_framing(err_framing)
`endif
  );

  // Pairs of entries form polynomials; in_sub on odd entries is deliberately contrary and must be ignored.
  int t_b [NV][LANES] = '{
    '{90, 0, 96, 50}, '{96, 1, 0, 10}, '{5, 0, 96, 20}, '{0, 8, 0, 3},
    '{1, 95, 40, 70}, '{2, 60, 30, 88}, '{50, 10, 0, 96}, '{7, 64, 63, 1},
    '{11, 12, 13, 14}, '{1, 2, 3, 4}};
  int t_g [NV][LANES] = '{
    '{3, -1, 0, -13}, '{1, 32767, -32768, 12}, '{3, 0, -1, 2}, '{1, 1, 32767, -32768},
    '{4, -4, 100, -100}, '{5, 7, -2, 9}, '{5, 5, -5, 12}, '{-7, 8, 8, -12},
    '{1, 1, 1, 1}, '{2, 2, 2, 2}};
  int t_e [NV][LANES] = '{
    '{17, 89, 96, 43}, '{7, 43, 47, 9}, '{78, 0, 7, 4}, '{89, 0, 55, 53},
    '{33, 63, 64, 46}, '{42, 19, 14, 63}, '{10, 67, 40, 0}, '{63, 0, 96, 0},
    '{19, 20, 21, 22}, '{17, 18, 19, 20}};
  logic t_sub [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic t_lin [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic t_elast [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  int   n_chk = 0, n_pass = 0;
  int   mon_ptr = 0, fire_cnt = 0;
  logic prev_stall = 1'b0;
  logic [LANES*W*2+1:0] prev_out;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [LANES*W-1:0] vec(input int sel, input int i);
    logic [LANES*W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*W +: W] = W'((sel == 0) ? t_b[i][l] : (sel == 1) ? t_g[i][l] : t_e[i][l]);
    return r;
  endfunction

  function automatic logic [LANES*W-1:0] a_of(input int i);
    return {16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i), 16'hD000 + 16'(i)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) check("hold", {out_valid, out_last, out_a, out_b}, prev_out);
      if (out_valid && out_ready) begin
        if (mon_ptr >= NV) check("extra_beat", mon_ptr, NV - 1);
        else begin
          check($sformatf("out_a[%0d]", mon_ptr), out_a, a_of(mon_ptr));
          check($sformatf("out_b[%0d]", mon_ptr), out_b, vec(2, mon_ptr));
          check($sformatf("out_last[%0d]", mon_ptr), out_last, t_elast[mon_ptr]);
          mon_ptr++;
        end
        fire_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_last, out_a, out_b};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int first, input int cnt, input logic [3:0] pat, output int cyc);
    int sent;
    sent = 0;
    cyc  = 0;
    while (sent < cnt && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = 1'b1;
      in_a      = a_of(first + sent);
      in_b      = vec(0, first + sent);
      in_gamma  = vec(1, first + sent);
      in_sub    = t_sub[first + sent];
      in_last   = t_lin[first + sent];
      #1;
      if (in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sent < cnt) check("stream_timeout", sent, cnt);
  endtask

  task automatic drain(input int target, input string tag);
    int n;
    n = 0;
    while (mon_ptr < target && n < 60) begin
      tick();
      n++;
    end
    check(tag, mon_ptr, target);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; in_gamma = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_ab", {out_a, out_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", in_ready, 1'b0);
    tick();
    check("rdy_after_edge", in_ready, 1'b1);

    // Single beat, exact latency: valid appears after the third edge counting the accepting one
    stream(0, 1, 4'b1111, cyc);
    check("lat_c1", out_valid, 1'b0);
    tick();
    check("lat_c2", out_valid, 1'b0);
    tick();
    check("lat_c3", out_valid, 1'b1);
    check("lat_b", out_b, vec(2, 0));
    stream(1, 1, 4'b1111, cyc);
    drain(2, "t1_count");

    // Six beats with out_ready cycling 1,0,0,1
    stream(2, 6, 4'b1001, cyc);
    drain(8, "t2_count");
    repeat (3) tick();
    check("t2_no_dup", fire_cnt, 8);

    // Back-to-back add/sub polynomials at full rate
    mon_ptr  = 0;
    fire_cnt = 0;
    stream(0, 8, 4'b1111, cyc);
    check("t3_in_cycles", cyc, 8);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t3_out_burst", fire_cnt, 8);
    drain(8, "t3_count");
`ifdef CT_PT_ADDSUB_FRAMING_CHECK_EN
    check("err_clean", err_framing, 1'b0);
`endif

    // Reset with one beat parked at the output
    stream(8, 1, 4'b0000, cyc);
    out_ready = 1'b0;
    tick();
    tick();
    check("t4_parked", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", out_valid, 1'b0);
    check("t4_rst_ready", in_ready, 1'b0);
    check("t4_rst_b", out_b, '0);
`ifdef CT_PT_ADDSUB_FRAMING_CHECK_EN
    check("t4_rst_err", err_framing, 1'b0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t4_rdy_back", in_ready, 1'b1);
    mon_ptr = 8;
    stream(8, 2, 4'b1111, cyc);
    drain(10, "t4_count");
`ifdef CT_PT_ADDSUB_FRAMING_CHECK_EN
    check("err_set", err_framing, 1'b1);
    repeat (3) tick();
    check("err_sticky", err_framing, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
